// File: rtl/intr_pkg.sv
// Shared definitions for the prioritised interrupt controller: register map,
// FSM encoding and the "no request" interrupt number.
package intr_pkg;

  localparam int OFF_IPEND = 0;
  localparam int OFF_IMASK = 2;
  localparam int OFF_ISERV = 4;
  localparam int OFF_EOI   = 6;

  // Source indices fit in 4 bits since at most 14 sources are supported.
  localparam int IDXW = 4;

  localparam logic [3:0] NULLNUM = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder; index 0 is the highest priority.
module prio_enc
  import intr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    vec_i,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDXW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped prioritised interrupt controller: edge-latched pending bits,
// mask, in-service tracking and a REQ/ACK handshake towards the CPU.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int               ABITS    = 16,
  parameter int               DBITS    = 16,
  parameter int               NSRC     = 4,
  parameter logic [ABITS-1:0] RBASE    = 16'hFFD0,
  parameter int               FIRSTNUM = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             LOCK,
  input  logic [ABITS-1:0] ABUS,
  inout  wire  [DBITS-1:0] RBUS,
  input  logic             RE,
  input  logic [DBITS-1:0] WBUS,
  input  logic             WE,
  input  logic [NSRC-1:0]  IRQ,
  input  logic             ACK,
  output logic             INTREQ,
  output logic [3:0]       INTNUM
);

  logic [NSRC-1:0] prev_irq_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] serv_q, serv_d;
  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            intreq_q, intreq_d;
  logic [3:0]      intnum_q, intnum_d;

  // Address decode and bus write strobes.
  logic hit_pend, hit_mask, hit_serv, hit_eoi;
  logic wr_en, wr_pend, wr_mask, wr_eoi;
  logic [NSRC-1:0] wdata;
  logic unused_wbus;

  assign hit_pend = (ABUS == RBASE + ABITS'(OFF_IPEND));
  assign hit_mask = (ABUS == RBASE + ABITS'(OFF_IMASK));
  assign hit_serv = (ABUS == RBASE + ABITS'(OFF_ISERV));
  assign hit_eoi  = (ABUS == RBASE + ABITS'(OFF_EOI));

  assign wr_en   = WE & LOCK;
  assign wr_pend = wr_en & hit_pend;
  assign wr_mask = wr_en & hit_mask;
  assign wr_eoi  = wr_en & hit_eoi;
  assign wdata   = WBUS[NSRC-1:0];
  assign unused_wbus = ^WBUS[DBITS-1:NSRC];

  // Arbitration.
  logic [NSRC-1:0] edges, cand, idx_bit, serv_low;
  logic [IDXW-1:0] win_idx, serv_idx;
  logic            win_valid, serv_valid, eligible, ack_take;

  assign edges = IRQ & ~prev_irq_q;
  assign cand  = pend_q & mask_q;

  prio_enc #(.N(NSRC)) u_win (
    .vec_i   (cand),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  prio_enc #(.N(NSRC)) u_serv (
    .vec_i   (serv_q),
    .idx_o   (serv_idx),
    .valid_o (serv_valid)
  );

  assign eligible = win_valid & (~serv_valid | (win_idx < serv_idx));
  assign ack_take = ACK & (state_q == ST_REQ);
  assign idx_bit  = NSRC'(1) << idx_q;
  assign serv_low = NSRC'(1) << serv_idx;

  // Ordering inside each block encodes the simultaneous-event priorities:
  // edges set after clears, and EOI clears before the ACK bit is set.
  always_comb begin
    mask_d = wr_mask ? wdata : mask_q;

    pend_d = pend_q;
    if (wr_pend)  pend_d = pend_d & ~wdata;
    if (ack_take) pend_d = pend_d & ~idx_bit;
    pend_d = pend_d | edges;

    serv_d = serv_q;
    if (wr_eoi && serv_valid) serv_d = serv_d & ~serv_low;
    if (ack_take)             serv_d = serv_d | idx_bit;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    intreq_d = intreq_q;
    intnum_d = intnum_q;
    unique case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          state_d  = ST_REQ;
          idx_d    = win_idx;
          intreq_d = 1'b1;
          intnum_d = 4'(FIRSTNUM) + win_idx;
        end
      end
      ST_REQ: begin
        if (ack_take) begin
          state_d  = ST_HOLD;
          intreq_d = 1'b0;
          intnum_d = NULLNUM;
        end else if (((mask_d & idx_bit) == '0) || ((pend_d & idx_bit) == '0)) begin
          // Request withdrawn by software before the CPU took it.
          state_d  = ST_IDLE;
          intreq_d = 1'b0;
          intnum_d = NULLNUM;
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: begin
        state_d  = ST_IDLE;
        intreq_d = 1'b0;
        intnum_d = NULLNUM;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      prev_irq_q <= IRQ;
      pend_q     <= '0;
      mask_q     <= '0;
      serv_q     <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      intreq_q   <= 1'b0;
      intnum_q   <= NULLNUM;
    end else if (LOCK) begin
      prev_irq_q <= IRQ;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      serv_q     <= serv_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      intreq_q   <= intreq_d;
      intnum_q   <= intnum_d;
    end
  end

  assign INTREQ = intreq_q;
  assign INTNUM = intnum_q;

  // Read path.
  logic             rd_hit;
  logic [DBITS-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (hit_pend)      rd_data = DBITS'(pend_q);
    else if (hit_mask) rd_data = DBITS'(mask_q);
    else if (hit_serv) rd_data = DBITS'(serv_q);
    else if (hit_eoi)  rd_data = DBITS'(intnum_q);
  end

  assign rd_hit = RE & (hit_pend | hit_mask | hit_serv | hit_eoi);
  assign RBUS   = rd_hit ? rd_data : {DBITS{1'bz}};

endmodule
